// File: rtl/median_window_engine_pkg.sv
// ---------------------------------------------------------------------------
// median_window_engine_pkg
// Shared constants, FSM state encoding, pixel-window type and address helpers
// for the median window engine.
// No ports (package).
// ---------------------------------------------------------------------------
package median_window_engine_pkg;

    localparam int WIDTH  = 430;   // image width in pixels (columns, w)
    localparam int LENGTH = 554;   // image length in pixels (rows, l)
    localparam int PIX_W  = 8;     // pixel bit width
    localparam int ADDR_W = 18;    // memory address width
    localparam int W_BITS = 9;     // width of the w origin input
    localparam int L_BITS = 10;    // width of the l origin input
    localparam int N_PIX  = 9;     // pixels in a 3x3 window

    // Largest origin that still keeps the whole 3x3 window inside the image.
    localparam logic [W_BITS-1:0] W_MAX = W_BITS'(WIDTH - 3);
    localparam logic [L_BITS-1:0] L_MAX = L_BITS'(LENGTH - 3);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_SORT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef logic [N_PIX-1:0][PIX_W-1:0] pix_arr_t;

    // Linear address of pixel (row, col), unsigned at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ADDR_W-1:0] row,
                                                     input logic [ADDR_W-1:0] col);
        return row * ADDR_W'(WIDTH) + col;
    endfunction

    // Address of window element idx (0..8, row-major, top-left first).
    function automatic logic [ADDR_W-1:0] win_addr(input logic [L_BITS-1:0] row0,
                                                   input logic [W_BITS-1:0] col0,
                                                   input logic [3:0]        idx);
        logic [ADDR_W-1:0] dr;
        logic [ADDR_W-1:0] dc;
        dr = (idx >= 4'd6) ? ADDR_W'(2) : (idx >= 4'd3) ? ADDR_W'(1) : '0;
        case (idx)
            4'd0, 4'd3, 4'd6: dc = '0;
            4'd1, 4'd4, 4'd7: dc = ADDR_W'(1);
            default:          dc = ADDR_W'(2);
        endcase
        return pixel_addr(ADDR_W'(row0) + dr, ADDR_W'(col0) + dc);
    endfunction

endpackage

// File: rtl/median_window_engine_if.sv
// ---------------------------------------------------------------------------
// median_window_engine_if
// Bundles the sequencer handshake and both image-memory ports of the engine.
//   enable_filter, w, l          : sequencer request and window origin
//   filter_done, busy, range_err : status back to the sequencer
//   rd_en, rd_addr, rd_data      : input-image memory (synchronous read)
//   wr_en, wr_addr, wr_data      : output-image memory
// Modports: slave = engine side, master = sequencer/memory side.
// ---------------------------------------------------------------------------
interface median_window_engine_if;
    import median_window_engine_pkg::*;

    logic              enable_filter;
    logic [W_BITS-1:0] w;
    logic [L_BITS-1:0] l;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              filter_done;
    logic              busy;
    logic              range_err;

    modport slave (
        input  enable_filter, w, l, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, filter_done, busy, range_err
    );

    modport master (
        output enable_filter, w, l, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, filter_done, busy, range_err
    );

endinterface

// File: rtl/median_window_engine_median9_net.sv
// ---------------------------------------------------------------------------
// median9_net
// Combinational 19 compare-exchange network returning the 5th smallest of
// nine unsigned pixels (duplicates counted).
//   pix    : nine input pixels
//   median : median value (not registered)
// ---------------------------------------------------------------------------
module median9_net
    import median_window_engine_pkg::*;
(
    input  pix_arr_t         pix,
    output logic [PIX_W-1:0] median
);

    localparam int N_CE = 19;

    // Each step leaves the smaller value at CE_A and the larger at CE_B.
    localparam logic [3:0] CE_A [N_CE] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
                                           4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
    localparam logic [3:0] CE_B [N_CE] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
                                           4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

    logic [PIX_W-1:0] v [N_PIX];
    logic [PIX_W-1:0] lo;
    logic [PIX_W-1:0] hi;

    // NOTE: blocking assignments here on purpose -- each compare-exchange
    // must see the result of the previous one within the same evaluation.
    always_comb begin
        lo = '0;
        hi = '0;
        for (int i = 0; i < N_PIX; i++) v[i] = pix[i];
        for (int s = 0; s < N_CE; s++) begin
            lo = (v[CE_A[s]] < v[CE_B[s]]) ? v[CE_A[s]] : v[CE_B[s]];
            hi = (v[CE_A[s]] < v[CE_B[s]]) ? v[CE_B[s]] : v[CE_A[s]];
            v[CE_A[s]] = lo;
            v[CE_B[s]] = hi;
        end
        median = v[4];
    end

endmodule

// File: rtl/median_window_engine.sv
// ---------------------------------------------------------------------------
// median_window_engine
// Fetches a 3x3 window at origin (w, l) from the input image, computes its
// median and writes it to the output image at the window centre, then holds
// filter_done until the sequencer drops enable_filter.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : median_window_engine_if.slave (handshake + both memory ports)
// All outputs except busy are registered; busy is decoded from the state.
// ---------------------------------------------------------------------------
module median_window_engine
    import median_window_engine_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    median_window_engine_if.slave   bus
);

    state_t            state;
    state_t            state_next;
    logic [W_BITS-1:0] w_q;
    logic [L_BITS-1:0] l_q;
    logic [3:0]        k;        // index of the read currently on rd_addr
    logic              cap_en;   // memory sampled a read on the last edge
    logic [3:0]        cap_idx;  // window index of that read
    pix_arr_t          pix;
    logic [PIX_W-1:0]  median;
    logic              origin_ok;

    assign origin_ok = (bus.w <= W_MAX) && (bus.l <= L_MAX);
    assign bus.busy  = (state != S_IDLE);

    median9_net u_median9_net (
        .pix    (pix),
        .median (median)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.enable_filter) state_next = origin_ok ? S_READ : S_DONE;
            S_READ:  if (!bus.enable_filter) state_next = S_IDLE;
                     else if (k == 4'd8)     state_next = S_CAPT;
            S_CAPT:  state_next = bus.enable_filter ? S_SORT  : S_IDLE;
            S_SORT:  state_next = bus.enable_filter ? S_WRITE : S_IDLE;
            S_WRITE: state_next = S_DONE;
            S_DONE:  if (!bus.enable_filter) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pixel registers are cleared here too, so a reset
            // leaves no stale window data behind.
            bus.rd_en       <= 1'b0;
            bus.rd_addr     <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.filter_done <= 1'b0;
            bus.range_err   <= 1'b0;
            w_q             <= '0;
            l_q             <= '0;
            k               <= '0;
            cap_en          <= 1'b0;
            cap_idx         <= '0;
            pix             <= '0;
        end else begin
            bus.rd_en <= (state_next == S_READ);
            cap_en    <= bus.rd_en;
            cap_idx   <= k;

            // Read data is valid one edge after the memory sampled rd_addr.
            if (cap_en) pix[cap_idx] <= bus.rd_data;

            if (state == S_IDLE && bus.enable_filter) begin
                bus.range_err <= !origin_ok;
                if (origin_ok) begin
                    w_q         <= bus.w;
                    l_q         <= bus.l;
                    k           <= '0;
                    bus.rd_addr <= win_addr(bus.l, bus.w, 4'd0);
                end
            end

            if (state == S_READ && state_next == S_READ) begin
                k           <= k + 4'd1;
                bus.rd_addr <= win_addr(l_q, w_q, k + 4'd1);
            end

            bus.wr_en <= (state == S_SORT) && (state_next == S_WRITE);
            if (state == S_SORT && state_next == S_WRITE) begin
                bus.wr_data <= median;
                bus.wr_addr <= win_addr(l_q, w_q, 4'd4);
            end

            // Out-of-range requests enter DONE directly, so done rises one
            // edge later for them than for completed windows.
            bus.filter_done <= (state == S_WRITE) || (state == S_DONE && bus.enable_filter);
        end
    end

endmodule
